rs_pipe: RTL and testbench

//  8-bit right barrel shifter, pipelined, with valid/ready flow control.

---
 rtl/rs_pkg.sv | 9 +
 rtl/rs_pipe_if.sv | 19 +
 rtl/rs_stage.sv | 53 +++++
 rtl/rs_pipe.sv | 53 +++++
 tb/tb_rs_pipe.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/rs_pkg.sv
// Shared constants for the pipelined right barrel shifter.
package rs_pkg;
  localparam int W    = 8;
  localparam int NSTG = 3;

  localparam logic [1:0] MODE_LSR = 2'b00;
  localparam logic [1:0] MODE_ASR = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;
endpackage

// File: rtl/rs_pipe_if.sv
// Producer/consumer valid/ready bundle for rs_pipe.
interface rs_pipe_if;
  import rs_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   I;
  logic [2:0]     S;
  logic [1:0]     M;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   O;
  logic [1:0]     occ;

  modport slave  (input  in_valid, I, S, M, out_ready,
                  output in_ready, out_valid, O, occ);
  modport master (output in_valid, I, S, M, out_ready,
                  input  in_ready, out_valid, O, occ);
endinterface

// File: rtl/rs_stage.sv
// One registered shift stage: conditionally shifts right by SH on s_in[log2 SH].
module rs_stage
  import rs_pkg::*;
#(
  parameter int SH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  output logic         up_ready,
  output logic         dn_valid,
  input  logic         dn_ready,
  input  logic [W-1:0] d,
  input  logic [2:0]   s_in,
  input  logic [1:0]   m_in,
  output logic [W-1:0] q,
  output logic [2:0]   s_out,
  output logic [1:0]   m_out
);
  localparam int B = $clog2(SH);

  logic [W-1:0] sh_d;

  assign up_ready = ~dn_valid | dn_ready;

  // Unknown mode 11 falls through to a logical shift.
  always_comb begin
    sh_d = d;
    if (s_in[B]) begin
      case (m_in)
        MODE_ASR: sh_d = {{SH{d[W-1]}}, d[W-1:SH]};
        MODE_ROR: sh_d = {d[SH-1:0], d[W-1:SH]};
        default:  sh_d = {{SH{1'b0}}, d[W-1:SH]};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_valid <= 1'b0;
      q        <= '0;
      s_out    <= '0;
      m_out    <= '0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) begin
        q     <= sh_d;
        s_out <= s_in;
        m_out <= m_in;
      end
    end
  end
endmodule

// File: rtl/rs_pipe.sv
// Three-stage right barrel shifter (weights 1/2/4) with a combinational
// ready chain; a full pipe still accepts when the tail drains.
module rs_pipe
  import rs_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  rs_pipe_if.slave bus
);
  logic [NSTG:0]        vld_pipe;
  logic [NSTG:0][W-1:0] dat;
  logic [NSTG:0][2:0]   s_pipe;
  logic [NSTG:0][1:0]   m_pipe;
  logic                 rdy0, rdy1, rdy2;
  logic                 unused_sm;

  assign vld_pipe[0] = bus.in_valid;
  assign dat[0]      = bus.I;
  assign s_pipe[0]   = bus.S;
  assign m_pipe[0]   = bus.M;

  rs_stage #(.SH(1)) u_stg0 (
    .clk(clk), .rst_n(rst_n),
    .up_valid(vld_pipe[0]), .up_ready(rdy0),
    .dn_valid(vld_pipe[1]), .dn_ready(rdy1),
    .d(dat[0]), .s_in(s_pipe[0]), .m_in(m_pipe[0]),
    .q(dat[1]), .s_out(s_pipe[1]), .m_out(m_pipe[1])
  );

  rs_stage #(.SH(2)) u_stg1 (
    .clk(clk), .rst_n(rst_n),
    .up_valid(vld_pipe[1]), .up_ready(rdy1),
    .dn_valid(vld_pipe[2]), .dn_ready(rdy2),
    .d(dat[1]), .s_in(s_pipe[1]), .m_in(m_pipe[1]),
    .q(dat[2]), .s_out(s_pipe[2]), .m_out(m_pipe[2])
  );

  rs_stage #(.SH(4)) u_stg2 (
    .clk(clk), .rst_n(rst_n),
    .up_valid(vld_pipe[2]), .up_ready(rdy2),
    .dn_valid(vld_pipe[3]), .dn_ready(bus.out_ready),
    .d(dat[2]), .s_in(s_pipe[2]), .m_in(m_pipe[2]),
    .q(dat[3]), .s_out(s_pipe[3]), .m_out(m_pipe[3])
  );

  // Final stage's control fields have no consumer.
  assign unused_sm = ^{s_pipe[NSTG], m_pipe[NSTG]};

  assign bus.in_ready  = rdy0;
  assign bus.out_valid = vld_pipe[NSTG];
  assign bus.O         = dat[NSTG];
  assign bus.occ       = {1'b0, vld_pipe[1]} + {1'b0, vld_pipe[2]} + {1'b0, vld_pipe[3]};
endmodule

// File: tb/tb_rs_pipe.sv
// Scoreboard bench for rs_pipe: expected words queued at accept, popped at drain.
module tb_rs_pipe;
  import rs_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rs_pipe_if bus();

  rs_pipe u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_drain = 0;
  bit   acc;
  logic [7:0] sb [$];
  logic [7:0] dq [$];

  function automatic logic [7:0] ref_shr(input logic [7:0] d, input logic [2:0] s,
                                         input logic [1:0] m);
    logic [15:0] dd;
    case (m)
      2'b01:   return 8'($signed(d) >>> s);
      2'b10:   begin dd = {d, d} >> s; return dd[7:0]; end
      default: return d >> s;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] i, input logic [2:0] s,
                       input logic [1:0] m);
    bus.in_valid = v;
    bus.I        = i;
    bus.S        = s;
    bus.M        = m;
  endtask

  // One clock: record handshakes at the negedge, then step past the posedge.
  task automatic cyc();
    logic [7:0] e;
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      n_drain++;
      if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
      else begin
        e = sb.pop_front();
        chk("out_data", 32'(bus.O), 32'(e));
      end
    end
    if (acc) begin
      if (dq.size() != 0) sb.push_back(dq.pop_front());
      else sb.push_back(ref_shr(bus.I, bus.S, bus.M));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < budget && sb.size() != 0; c++) cyc();
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  logic [7:0] exp2 [3] = '{8'h16, 8'hF6, 8'h96};
  logic [7:0] exp3 [8] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] wi [4];
    logic [2:0] ws [4];
    logic [1:0] wm [4];
    logic [7:0] hold;
    int idx, nd0;

    drive(1'b0, 8'h00, 3'd0, 2'd0);
    bus.out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_O",         32'(bus.O),         32'd0);
    chk("rst_occ",       32'(bus.occ),       32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Mid-stream reset drops in-flight words immediately
    drive(1'b1, 8'hA5, 3'd1, 2'd0); cyc();
    drive(1'b1, 8'h5A, 3'd2, 2'd1); cyc();
    drive(1'b0, 8'h00, 3'd0, 2'd0); cyc();
    chk("pre_rst_occ", 32'(bus.occ), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_O",         32'(bus.O),         32'd0);
    chk("mid_rst_occ",       32'(bus.occ),       32'd0);
    chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc();
      chk("post_rst_quiet", 32'(bus.out_valid), 32'd0);
    end

    // Latency and the three modes on B4 >> 3
    for (int k = 0; k < 3; k++) begin
      dq.push_back(exp2[k]);
      drive(1'b1, 8'hB4, 3'd3, 2'(k));
      cyc();
      chk("t2_acc", 32'(acc), 32'd1);
      drive(1'b0, 8'h00, 3'd0, 2'd0);
      chk("t2_lat1", 32'(bus.out_valid), 32'd0);
      cyc();
      chk("t2_lat2", 32'(bus.out_valid), 32'd0);
      cyc();
      chk("t2_lat3", 32'(bus.out_valid), 32'd1);
      chk("t2_O",    32'(bus.O), 32'(exp2[k]));
      cyc();
    end

    // Back-to-back arithmetic stream
    nd0 = n_drain;
    for (int s = 0; s < 8; s++) begin
      dq.push_back(exp3[s]);
      drive(1'b1, 8'h80, 3'(s), 2'b01);
      chk("t3_in_ready", 32'(bus.in_ready), 32'd1);
      cyc();
    end
    drive(1'b0, 8'h00, 3'd0, 2'd0);
    repeat (3) cyc();
    chk("t3_drains", 32'(n_drain - nd0), 32'd8);
    chk("t3_sb",     32'(sb.size()),     32'd0);

    // Backpressure: four words offered into a stalled pipe
    for (int k = 0; k < 4; k++) begin
      wi[k] = 8'($urandom); ws[k] = 3'($urandom); wm[k] = 2'($urandom);
    end
    bus.out_ready = 1'b0;
    nd0 = n_drain;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      drive(idx < 4, wi[idx%4], ws[idx%4], wm[idx%4]);
      cyc();
      if (acc) idx++;
    end
    chk("t4_accepted", 32'(idx),           32'd3);
    chk("t4_occ",      32'(bus.occ),       32'd3);
    chk("t4_in_ready", 32'(bus.in_ready),  32'd0);
    chk("t4_out_valid",32'(bus.out_valid), 32'd1);
    hold = bus.O;
    repeat (2) cyc();
    chk("t4_O_stable", 32'(bus.O), 32'(hold));
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && !(idx == 4 && sb.size() == 0); c++) begin
      drive(idx < 4, wi[idx%4], ws[idx%4], wm[idx%4]);
      cyc();
      if (acc) idx++;
    end
    chk("t4_all_in",  32'(idx),             32'd4);
    chk("t4_drains",  32'(n_drain - nd0),   32'd4);
    chk("t4_sb",      32'(sb.size()),       32'd0);

    // Bubble collapse with the output stalled
    bus.out_ready = 1'b0;
    drive(1'b1, 8'h3C, 3'd1, 2'b00); cyc();
    chk("t5_occ_a", 32'(bus.occ), 32'd1);
    drive(1'b0, 8'h00, 3'd0, 2'd0);  cyc();
    chk("t5_occ_b", 32'(bus.occ), 32'd1);
    cyc();
    chk("t5_occ_c", 32'(bus.occ), 32'd1);
    drive(1'b1, 8'hC3, 3'd5, 2'b10); cyc();
    chk("t5_acc_b", 32'(acc), 32'd1);
    chk("t5_occ_d", 32'(bus.occ), 32'd2);
    drive(1'b1, 8'h81, 3'd6, 2'b01); cyc();
    chk("t5_acc_c", 32'(acc), 32'd1);
    chk("t5_occ_e", 32'(bus.occ), 32'd3);
    drive(1'b0, 8'h00, 3'd0, 2'd0);
    chk("t5_in_ready", 32'(bus.in_ready), 32'd0);
    drain(10);

    // Random traffic against the reference model
    for (int c = 0; c < 10000; c++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), 3'($urandom), 2'($urandom));
      bus.out_ready = $urandom_range(0, 3) != 0;
      cyc();
    end
    drain(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
